// File: rtl/verin_pkg.sv
// verin_pkg: shared types and constants for the SOPC_verin actuator command path.
//   arb_state_t   : arbiter FSM states
//   PIO_ADDR_DATA : Avalon address of the PIO data register
//   REQ_AUTO/MAN  : requester IDs (auto servo loop / manual software path)
package verin_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, GAP} arb_state_t;
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic REQ_AUTO = 1'b0;
    localparam logic REQ_MAN  = 1'b1;
endpackage

// File: rtl/verin_rr_arb2.sv
// verin_rr_arb2: combinational two-way round-robin pick.
//   req0, req1 : requests
//   last_id    : ID granted most recently (the loser of a tie)
//   valid      : any request present
//   win_id     : selected requester ID
module verin_rr_arb2
    import verin_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_id,
    output logic valid,
    output logic win_id
);
    assign valid  = req0 | req1;
    assign win_id = (req0 && req1) ? ~last_id : (req1 ? REQ_MAN : REQ_AUTO);
endmodule

// File: rtl/verin_pio_arbiter.sv
// verin_pio_arbiter: round-robin arbiter issuing rate-limited single-cycle writes to the actuator PIO.
//   clk, reset_n         : clock, asynchronous active-low reset
//   req0/data0/gnt0      : auto servo loop requester
//   req1/data1/gnt1      : manual command requester
//   pio_*                : Avalon-MM write master toward the PIO data register
//   busy                 : FSM not idle
//   last_data            : shadow of the last byte written
module verin_pio_arbiter
    import verin_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    output logic              busy,
    output logic [DATA_W-1:0] last_data
);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    arb_state_t        state_q;
    logic [DATA_W-1:0] cmd_q, cmd_d, last_data_q;
    logic [7:0]        gap_q;
    logic              win_q, ptr_q, gnt0_q, gnt1_q, cs_q;
    logic              valid, win_d;

    verin_rr_arb2 u_arb (
        .req0    (req0),
        .req1    (req1),
        .last_id (ptr_q),
        .valid   (valid),
        .win_id  (win_d)
    );

    assign cmd_d = (win_d == REQ_MAN) ? data1 : data0;

    // ptr_q holds the ID granted last; resetting it to REQ_MAN makes req0 win the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            last_data_q <= '0;
            gap_q       <= '0;
            win_q       <= REQ_AUTO;
            ptr_q       <= REQ_MAN;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            cs_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (valid) begin
                    state_q <= WRITE;
                    cmd_q   <= cmd_d;
                    win_q   <= win_d;
                    gnt0_q  <= (win_d == REQ_AUTO);
                    gnt1_q  <= (win_d == REQ_MAN);
                    cs_q    <= 1'b1;
                end
                WRITE: begin
                    gnt0_q      <= 1'b0;
                    gnt1_q      <= 1'b0;
                    cs_q        <= 1'b0;
                    last_data_q <= cmd_q;
                    ptr_q       <= win_q;
                    gap_q       <= GAP_LOAD;
                    state_q     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                end
                GAP: begin
                    if (gap_q == 8'd0) state_q <= IDLE;
                    else gap_q <= gap_q - 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    assign pio_address    = PIO_ADDR_DATA;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = ~cs_q;
    assign pio_writedata  = cs_q ? {{(32-DATA_W){1'b0}}, cmd_q} : 32'd0;
    assign busy           = (state_q != IDLE);
    assign last_data      = last_data_q;
endmodule

// File: tb/tb_verin_pio_arbiter.sv
// tb_verin_pio_arbiter: scoreboard bench for verin_pio_arbiter (GAP_CYCLES=4 and GAP_CYCLES=0 builds).
module tb_verin_pio_arbiter;
    typedef struct {
        logic       id;
        logic [7:0] data;
        int         at;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   na = 0;
    int   nb = 0;
    wr_t  qa[$];
    wr_t  qb[$];
    wr_t  ea, eb;

    logic        a_req0 = 0, a_req1 = 0, a_gnt0, a_gnt1, a_cs, a_wr_n, a_busy;
    logic [7:0]  a_data0 = 0, a_data1 = 0, a_last;
    logic [1:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_req0 = 0, b_req1 = 0, b_gnt0, b_gnt1, b_cs, b_wr_n, b_busy;
    logic [7:0]  b_data0 = 0, b_data1 = 0, b_last;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;

    verin_pio_arbiter #(.DATA_W(8), .GAP_CYCLES(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req0(a_req0), .data0(a_data0), .gnt0(a_gnt0),
        .req1(a_req1), .data1(a_data1), .gnt1(a_gnt1),
        .pio_address(a_addr), .pio_chipselect(a_cs), .pio_write_n(a_wr_n),
        .pio_writedata(a_wdata), .busy(a_busy), .last_data(a_last)
    );

    verin_pio_arbiter #(.DATA_W(8), .GAP_CYCLES(0)) u_dut_nogap (
        .clk(clk), .reset_n(reset_n),
        .req0(b_req0), .data0(b_data0), .gnt0(b_gnt0),
        .req1(b_req1), .data1(b_data1), .gnt1(b_gnt1),
        .pio_address(b_addr), .pio_chipselect(b_cs), .pio_write_n(b_wr_n),
        .pio_writedata(b_wdata), .busy(b_busy), .last_data(b_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) if (reset_n) begin
        if (a_cs) begin
            check("a_queue_nonempty", 32'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_wdata", a_wdata, {24'h0, ea.data});
                check("a_gnt", {a_gnt1, a_gnt0}, ea.id ? 2'b10 : 2'b01);
                check("a_addr_wrn", {a_addr, a_wr_n}, 3'b000);
                check("a_strobe_cycle", cyc, ea.at);
            end
            na++;
        end else check("a_idle_bus", {a_gnt1, a_gnt0, ~a_wr_n, a_addr, a_wdata != 0}, 0);
    end

    always @(negedge clk) if (reset_n) begin
        if (b_cs) begin
            check("b_queue_nonempty", 32'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("b_wdata", b_wdata, {24'h0, eb.data});
                check("b_gnt", {b_gnt1, b_gnt0}, eb.id ? 2'b10 : 2'b01);
                check("b_strobe_cycle", cyc, eb.at);
            end
            nb++;
        end else check("b_idle_bus", {b_gnt1, b_gnt0, ~b_wr_n, b_addr, b_wdata != 0}, 0);
    end

    task automatic wait_a(input int target);
        int n = 0;
        while (na < target && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_strobe_count", na, target);
    endtask

    task automatic wait_b(input int target);
        int n = 0;
        while (nb < target && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_strobe_count", nb, target);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("a_back_to_idle", a_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus", {a_cs, a_wr_n, a_addr, a_gnt1, a_gnt0}, 6'b010000);
        check("rst_wdata", a_wdata, 0);
        check("rst_busy_last", {a_busy, a_last}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single req0 write, then req1 arriving during GAP
        a_req0 = 1; a_data0 = 8'hA5;
        qa.push_back('{1'b0, 8'hA5, cyc + 1});
        wait_a(1);
        a_req0 = 0;
        check("t1_last_data", a_last, 8'hA5);
        check("t1_busy_in_gap", a_busy, 1);
        a_req1 = 1; a_data1 = 8'h3C;
        qa.push_back('{1'b1, 8'h3C, cyc + 5});
        wait_a(2);
        a_req1 = 0;
        check("t3_last_data", a_last, 8'h3C);
        wait_idle_a();

        // both held: alternate 11,22,11,22 six cycles apart
        a_req0 = 1; a_data0 = 8'h11; a_req1 = 1; a_data1 = 8'h22;
        for (int k = 0; k < 4; k++) qa.push_back('{1'(k % 2), (k % 2) ? 8'h22 : 8'h11, cyc + 1 + 6 * k});
        wait_a(6);
        a_req0 = 0; a_req1 = 0;
        wait_idle_a();

        // req1 alone keeps winning, then a tie goes to req0
        for (int i = 0; i < 3; i++) begin
            a_req1 = 1; a_data1 = 8'(8'h50 + i);
            qa.push_back('{1'b1, 8'(8'h50 + i), cyc + 1});
            wait_a(7 + i);
            a_req1 = 0;
            wait_idle_a();
        end
        a_req0 = 1; a_data0 = 8'h77; a_req1 = 1; a_data1 = 8'h88;
        qa.push_back('{1'b0, 8'h77, cyc + 1});
        qa.push_back('{1'b1, 8'h88, cyc + 7});
        wait_a(10);
        a_req0 = 0;
        wait_a(11);
        a_req1 = 0;
        wait_idle_a();
        check("t6_last_data", a_last, 8'h88);

        // reset asserted while the strobe is on the bus
        a_req0 = 1; a_data0 = 8'h5A;
        @(posedge clk); #1;
        check("t4_strobe_before_reset", {a_cs, a_gnt0}, 2'b11);
        reset_n = 0;
        #1;
        check("t4_bus_abort", {a_cs, a_wr_n, a_gnt0, a_gnt1}, 4'b0100);
        check("t4_last_busy", {a_busy, a_last}, 0);
        a_req0 = 0;
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;

        // GAP_CYCLES=0 build: req0 held over four bytes, strobes every 2 cycles
        b_req0 = 1; b_data0 = 8'hC1;
        for (int k = 0; k < 4; k++) qb.push_back('{1'b0, 8'(8'hC1 + k), cyc + 1 + 2 * k});
        for (int k = 0; k < 4; k++) begin
            wait_b(k + 1);
            if (k < 3) b_data0 = 8'(8'hC2 + k);
            else b_req0 = 0;
        end
        repeat (4) @(posedge clk);
        #1;
        check("t5_last_data", b_last, 8'hC4);
        check("t5_strobes", nb, 4);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/verin_pio_arbiter.md
# verin_pio_arbiter

- Shares the actuator command PIO's Avalon-MM slave port between two requesters: the automatic-mode servo loop (req0) and the manual/software command path (req1).
- Arbitrates round-robin and issues single-cycle Avalon writes to PIO data register address 0.
- Enforces a programmable minimum gap between consecutive writes to protect the actuator from command chatter.
- Sits in the SOPC_verin fabric, directly in front of the 8-bit output PIO.

## Interface

Parameters:
- DATA_W, 8: command byte width; must equal the PIO out_port width.
- GAP_CYCLES, 4: idle cycles forced after every write strobe; legal range 0..255.

Ports (name, direction, width, meaning):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  write request from requester 0 (auto loop).
- data0  in  DATA_W  command byte from requester 0.
- gnt0  out  1  one-cycle pulse: requester 0's byte is being written this cycle.
- req1  in  1  write request from requester 1 (manual path).
- data1  in  DATA_W  command byte from requester 1.
- gnt1  out  1  one-cycle pulse: requester 1's byte is being written this cycle.
- pio_address  out  2  Avalon address to PIO; always 0.
- pio_chipselect  out  1  Avalon chipselect to PIO.
- pio_write_n  out  1  Avalon write strobe, active-low.
- pio_writedata  out  32  write data: {zero pad, latched byte}.
- busy  out  1  high whenever state is not IDLE.
- last_data  out  DATA_W  shadow of the last byte written to the PIO.

## Operation

- FSM states: IDLE, WRITE, GAP.
- IDLE, no request asserted: remain in IDLE.
- IDLE, any req asserted: select the winner, latch its data into cmd_q, record the winner ID, go to WRITE.
- Winner rule, single request: that requester wins.
- Winner rule, both requests: the requester not granted most recently wins. After reset, the pointer favours req0.
- WRITE: lasts exactly one cycle.
  - Drives pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={(32-DATA_W)'b0, cmd_q}.
  - Pulses gnt of the winner only.
- On the edge ending WRITE:
  - last_data <= cmd_q.
  - The round-robin pointer updates to favour the other requester.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP:
  - Load gap counter with GAP_CYCLES-1 on entry.
  - Decrement each cycle; move to IDLE when the counter is 0.
  - Requests are ignored during GAP.
- Outside WRITE, bus outputs are inactive: chipselect=0, write_n=1, address=0, writedata=0.
- Requester contract:
  - Hold req and data stable until its gnt is seen.
  - Deassert req on the edge ending the gnt cycle.
  - A req still high in IDLE is treated as a new request and causes another write.
- No readback path: the arbiter never issues reads.
- The PIO readdata output is not connected to this block.

## Timing

- Reset values, all asynchronous on reset_n low:
  - state=IDLE, gnt0=gnt1=0, busy=0.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
  - last_data=0, cmd_q=0, gap counter=0, pointer favours req0.
- Latency: req sampled high in IDLE in cycle N produces the write strobe and gnt in cycle N+1, and last_data updated in N+2.
- Throughput with requests held continuously: write strobes every GAP_CYCLES+2 cycles (WRITE + GAP_CYCLES + IDLE decision).
- All outputs are registered or decoded from registered state; no combinational path from req/data to pio_* or gnt.
- Reset mid-WRITE: the strobe aborts immediately and no gnt completes. The requester must re-request after reset.
- Reset mid-GAP: the gap is discarded and the block returns to IDLE.
- Requests arriving during WRITE or GAP wait. If both are pending at IDLE, round-robin applies.
- GAP_CYCLES=0: WRITE returns directly to IDLE, with one IDLE cycle between strobes.

## Structure

- Shared package verin_pkg holds:
  - arb_state_t enum (IDLE, WRITE, GAP).
  - PIO_ADDR_DATA = 2'd0.
  - Requester ID constants REQ_AUTO = 0 and REQ_MAN = 1.
- One natural sub-module, verin_rr_arb2: a combinational two-way round-robin pick (inputs req0, req1, last_id; outputs valid, win_id).
  - Its pointer register stays in the parent.
- Gap counter width: 8 bits.

## Test plan

- Reset, then req0=1 with data0=8'hA5 -> one cycle later: chipselect=1, write_n=0, address=0, writedata=32'h000000A5, gnt0=1. Next cycle last_data=8'hA5.
- req0 and req1 both asserted (8'h11, 8'h22) and held, GAP_CYCLES=4 -> writes alternate 11, 22, 11, 22, with strobes exactly 6 cycles apart.
- req1 (8'h3C) asserted during GAP after a req0 write -> no strobe until GAP expires; write of 8'h3C with gnt1 on the cycle after the first IDLE.
- reset_n pulsed low during WRITE -> chipselect=0 and write_n=1 immediately, gnt0=0, last_data=0, busy=0.
- GAP_CYCLES=0 build, req0 held high for 4 consecutive byte values -> strobes every 2 cycles, each byte written exactly once.
- Only req1 repeatedly, pointer check -> req1 wins every time. Then both asserted -> req0 wins first, since req1 was last granted.
